// File: rtl/spi_slave.sv
// SPI slave that receives two-byte frames (hi, lo) and rebuilds a 0..9999 counter value
// as hi*100 + lo; the previous frame's low byte is echoed back on miso.
module spi_slave (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        ss,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  output logic [13:0] count_value,
  output logic        count_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, HI_BYTE, LO_BYTE, WAIT_END} state_t;

  state_t state, state_next;

  logic ss_s1, ss_s2, ss_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;

  logic [1:0]  settle;
  logic        armed;
  logic [7:0]  rx_shift;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_shift;
  logic        miso_bit;
  logic [7:0]  hi_byte;
  logic [7:0]  last_lo;
  logic        rise_pend;

  logic        ss_fall, ss_rise, rise_now;
  logic        sclk_rise, sclk_fall, in_frame;
  logic        lead_edge, trail_edge, sample_edge, shift_edge;
  logic        byte_done;
  logic [7:0]  byte_full;
  logic [13:0] count_calc;
  logic        hi_we, lo_we, count_we, err_set;

  // A fall is only trusted once ss has been seen high after reset, so a reset
  // in the middle of a frame cannot restart reception halfway through a byte.
  assign ss_fall   = ss_s3 & ~ss_s2 & armed;
  assign ss_rise   = ~ss_s3 & ss_s2;
  assign sclk_rise = ~sclk_s3 & sclk_s2;
  assign sclk_fall = sclk_s3 & ~sclk_s2;

  // Gating on the delayed ss stage lets an edge coincident with ss rising still count.
  assign in_frame    = (state != IDLE) & ~ss_s3;
  assign lead_edge   = in_frame & (cpol ? sclk_fall : sclk_rise);
  assign trail_edge  = in_frame & (cpol ? sclk_rise : sclk_fall);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  assign byte_done  = sample_edge & (bit_cnt == 3'd7);
  assign byte_full  = {rx_shift[6:0], mosi_s2};
  assign rise_now   = (ss_rise & ~byte_done) | rise_pend;
  assign count_calc = {6'd0, hi_byte} * 14'd100 + {6'd0, byte_full};

  assign miso = ~ss_s2 & (ss_fall ? (~cpha & last_lo[7]) : miso_bit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    count_we   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) state_next = HI_BYTE;
      end
      HI_BYTE: begin
        if (byte_done) begin
          state_next = LO_BYTE;
          hi_we      = 1'b1;
        end else if (rise_now) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      LO_BYTE: begin
        if (byte_done) begin
          state_next = WAIT_END;
          lo_we      = 1'b1;
          if (hi_byte <= 8'd99 && byte_full <= 8'd99) count_we = 1'b1;
          else                                        err_set  = 1'b1;
        end else if (rise_now) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      WAIT_END: begin
        if (rise_now) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_s1       <= 1'b1;
      ss_s2       <= 1'b1;
      ss_s3       <= 1'b1;
      sclk_s1     <= cpol;
      sclk_s2     <= cpol;
      sclk_s3     <= cpol;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      settle      <= 2'd0;
      armed       <= 1'b0;
      rx_shift    <= 8'd0;
      bit_cnt     <= 3'd0;
      tx_shift    <= 8'd0;
      miso_bit    <= 1'b0;
      hi_byte     <= 8'd0;
      last_lo     <= 8'd0;
      rise_pend   <= 1'b0;
      rx_data     <= 8'd0;
      rx_done     <= 1'b0;
      count_value <= 14'd0;
      count_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;

      // ss_s2 only reflects the real pin two cycles after reset releases.
      if (settle != 2'd2) settle <= settle + 2'd1;
      armed <= armed | ((settle == 2'd2) & ss_s2);

      rise_pend <= ss_rise & byte_done;

      if (ss_fall || rise_now) begin
        rx_shift <= 8'd0;
        bit_cnt  <= 3'd0;
      end else if (sample_edge) begin
        rx_shift <= byte_full;
        bit_cnt  <= bit_cnt + 3'd1;
      end

      // For cpha=1 the first leading edge moves the MSB out, so it is not preloaded.
      if (ss_fall) begin
        tx_shift <= cpha ? last_lo : {last_lo[6:0], 1'b0};
        miso_bit <= ~cpha & last_lo[7];
      end else if (shift_edge) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        miso_bit <= tx_shift[7];
      end

      if (hi_we) hi_byte <= byte_full;
      if (lo_we) last_lo <= byte_full;

      rx_done <= byte_done;
      if (byte_done) rx_data <= byte_full;

      count_valid <= count_we;
      if (count_we) count_value <= count_calc;

      frame_err <= err_set;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized scoreboard bench for spi_slave: a frame-level model predicts received
// bytes, counter updates, frame errors and echoed miso bytes.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        reset, cpol, cpha, ss, sclk, mosi;
  logic        miso;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [13:0] count_value;
  logic        count_valid;
  logic        frame_err;

  spi_slave dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .ss(ss), .sclk(sclk),
    .mosi(mosi), .miso(miso), .rx_data(rx_data), .rx_done(rx_done),
    .count_value(count_value), .count_valid(count_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int exp_rx[$];
  int exp_cnt[$];
  int exp_err[$];

  int model_count   = 0;
  int model_last_lo = 0;

  logic [7:0] frame_bytes [4];
  logic prev_rx, prev_cv, prev_fe;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (reset) begin
      prev_rx = 1'b0;
      prev_cv = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (rx_done) begin
        checkOutput("rx_done_width", int'(prev_rx), 0);
        if (exp_rx.size() > 0) checkOutput("rx_data", int'(rx_data), exp_rx.pop_front());
        else                   checkOutput("unexpected_rx_done", int'(rx_done), 0);
      end
      if (count_valid) begin
        checkOutput("count_valid_width", int'(prev_cv), 0);
        checkOutput("count_valid_with_rx_done", int'(rx_done), 1);
        if (exp_cnt.size() > 0) checkOutput("count_value", int'(count_value), exp_cnt.pop_front());
        else                    checkOutput("unexpected_count_valid", int'(count_valid), 0);
      end
      if (frame_err) begin
        checkOutput("frame_err_width", int'(prev_fe), 0);
        if (exp_err.size() > 0) void'(exp_err.pop_front());
        else                    checkOutput("unexpected_frame_err", int'(frame_err), 0);
      end
      prev_rx = rx_done;
      prev_cv = count_valid;
      prev_fe = frame_err;
    end
  end

  task automatic halfWait();
    repeat (8) @(negedge clk);
  endtask

  task automatic setMode(input bit p, input bit h);
    @(negedge clk);
    cpol = p;
    cpha = h;
    sclk = p;
    repeat (6) @(negedge clk);
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset_miso", int'(miso), 0);
    checkOutput("reset_rx_data", int'(rx_data), 0);
    checkOutput("reset_rx_done", int'(rx_done), 0);
    checkOutput("reset_count_value", int'(count_value), 0);
    checkOutput("reset_count_valid", int'(count_valid), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
  endtask

  // Drives one frame of nb bytes from frame_bytes. abort_bits >= 0 raises ss after
  // that many bits; fast_end raises ss together with the last sclk edge; rst_mid
  // pulses reset once the hi byte is in and keeps clocking the rest of the frame.
  task automatic applyStimulus(input int nb, input int abort_bits, input bit fast_end, input bit rst_mid);
    int limit;
    int done_bytes;
    int hi, lo;
    int exp_first_miso;
    logic [7:0] miso_acc;
    logic b;

    limit = (abort_bits >= 0 && !rst_mid) ? abort_bits : nb * 8;
    done_bytes = rst_mid ? 1 : limit / 8;
    exp_first_miso = model_last_lo;
    for (int k = 0; k < done_bytes; k++) exp_rx.push_back(int'(frame_bytes[k]));
    if (!rst_mid) begin
      if (done_bytes >= 2) begin
        hi = int'(frame_bytes[0]);
        lo = int'(frame_bytes[1]);
        if (hi <= 99 && lo <= 99) begin
          model_count = hi * 100 + lo;
          exp_cnt.push_back(model_count);
        end else begin
          exp_err.push_back(1);
        end
        model_last_lo = lo;
      end else begin
        exp_err.push_back(1);
      end
    end

    miso_acc = 8'd0;
    @(negedge clk);
    ss = 1'b0;
    halfWait();
    for (int i = 0; i < limit; i++) begin
      b = frame_bytes[i / 8][7 - (i % 8)];
      if (!cpha) begin
        mosi = b;
        halfWait();
        miso_acc = {miso_acc[6:0], miso};
        sclk = ~cpol;
        halfWait();
        if (i == limit - 1 && fast_end) ss = 1'b1;
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = b;
        halfWait();
        miso_acc = {miso_acc[6:0], miso};
        if (i == limit - 1 && fast_end) ss = 1'b1;
        sclk = cpol;
        halfWait();
      end
      if (i % 8 == 7) begin
        if (i / 8 == 0)      checkOutput("miso_byte0", int'(miso_acc), exp_first_miso);
        else if (i / 8 == 1) checkOutput("miso_byte1", int'(miso_acc), 0);
      end
      if (rst_mid && i == 7) begin
        repeat (4) @(negedge clk);
        checkOutput("rx_pending_before_reset", exp_rx.size(), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        reset = 1'b0;
        model_count   = 0;
        model_last_lo = 0;
      end
    end
    halfWait();
    ss = 1'b1;
    repeat (24) @(negedge clk);
    checkOutput("rx_pending", exp_rx.size(), 0);
    checkOutput("count_pending", exp_cnt.size(), 0);
    checkOutput("err_pending", exp_err.size(), 0);
    checkOutput("count_value_hold", int'(count_value), model_count);
  endtask

  task automatic setBytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    frame_bytes[0] = b0;
    frame_bytes[1] = b1;
    frame_bytes[2] = b2;
    frame_bytes[3] = 8'h00;
  endtask

  initial begin
    int nb, abort_bits;
    bit fe;
    reset = 1'b1;
    ss    = 1'b1;
    cpol  = 1'b0;
    cpha  = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (4) @(negedge clk);
    checkResetOutputs();
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Echo of the previous frame's low byte, starting from 0x00 after reset.
    setMode(0, 0);
    setBytes(8'h01, 8'h02, 8'h00); applyStimulus(2, -1, 0, 0);
    setBytes(8'h03, 8'h04, 8'h00); applyStimulus(2, -1, 0, 0);

    setBytes(8'h0C, 8'h22, 8'h00); applyStimulus(2, -1, 0, 0);

    setMode(0, 1); setBytes(8'h63, 8'h63, 8'h00); applyStimulus(2, -1, 0, 0);
    setMode(1, 0); setBytes(8'h63, 8'h63, 8'h00); applyStimulus(2, -1, 0, 0);
    setMode(1, 1); setBytes(8'h63, 8'h63, 8'h00); applyStimulus(2, -1, 0, 0);

    setMode(0, 0);
    setBytes(8'h64, 8'h00, 8'h00); applyStimulus(2, -1, 0, 0);
    setBytes(8'h00, 8'h07, 8'h00); applyStimulus(2, 5, 0, 0);
    applyStimulus(2, -1, 0, 0);

    setBytes(8'h12, 8'h34, 8'h00); applyStimulus(2, -1, 0, 1);
    setBytes(8'h00, 8'h05, 8'h00); applyStimulus(2, -1, 0, 0);

    // ss rising together with the 8th sample edge, and with the final edge of a frame.
    setMode(0, 1);
    setBytes(8'h2A, 8'h01, 8'h00); applyStimulus(2, 8, 1, 0);
    setBytes(8'h05, 8'h06, 8'h00); applyStimulus(2, -1, 1, 0);
    setMode(1, 0);
    setBytes(8'h10, 8'h20, 8'hFF); applyStimulus(3, -1, 0, 0);
    setBytes(8'h00, 8'h63, 8'h00); applyStimulus(2, 12, 0, 0);

    for (int f = 0; f < 24; f++) begin
      setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nb = int'($urandom_range(2, 3));
      for (int k = 0; k < 4; k++)
        frame_bytes[k] = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 99))
                                                    : 8'($urandom_range(100, 255));
      abort_bits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, nb * 8 - 1)) : -1;
      fe = cpha && ($urandom_range(0, 1) == 1);
      applyStimulus(nb, abort_bits, fe, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have these ports, one per line (name  direction  width  meaning):
  clk  in  1  system clock; all state updates on rising edge
  reset  in  1  synchronous active-high reset
  cpol  in  1  SPI clock idle level; static during a frame
  cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static during a frame
  ss  in  1  active-low slave select from master; asynchronous to clk
  sclk  in  1  SPI serial clock; asynchronous to clk; frequency <= clk/8
  mosi  in  1  serial data in, MSB first
  miso  out  1  serial data out, MSB first
  rx_data  out  8  last fully received byte
  rx_done  out  1  one-cycle pulse per received byte
  count_value  out  14  reconstructed counter value, 0..9999
  count_valid  out  1  one-cycle pulse when count_value updates
  frame_err  out  1  one-cycle pulse on malformed frame

Function
REQ-003 ss, sclk and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected by comparing sync stage 2 with a third stage.
REQ-004 Leading edge = sclk leaving the cpol level; trailing edge = sclk returning to it; edges SHALL be ignored while synchronized ss is high.
REQ-005 Sample edge: leading if cpha=0, trailing if cpha=1; on the sample-edge detect cycle, synchronized mosi SHALL shift into an 8-bit shift register LSB side, and a 3-bit bit counter SHALL increment.
REQ-006 On the 8th sample edge (bit counter wraps 7->0), rx_data SHALL load the completed byte and rx_done SHALL pulse high on the next clk cycle.
REQ-007 Synchronized ss falling SHALL clear the bit counter and shift register and load the miso shift register with the previous frame's low byte (0x00 after reset).
REQ-008 miso: for cpha=0 the MSB SHALL be on miso from the ss-fall detect cycle and the register SHALL shift on each trailing edge; for cpha=1 it SHALL shift on each leading edge, including the first; miso SHALL be 0 while ss is high.
REQ-009 Frame FSM states: IDLE, HI_BYTE, LO_BYTE, WAIT_END.
REQ-010 IDLE -> HI_BYTE on ss fall; HI_BYTE -> LO_BYTE on byte complete (stores hi byte); LO_BYTE -> WAIT_END on byte complete; WAIT_END -> IDLE on ss rise.
REQ-011 In WAIT_END, further bytes SHALL still produce rx_done but SHALL NOT change count_value or assert frame_err.
REQ-012 On lo byte complete: if hi <= 99 and lo <= 99, count_value SHALL load hi*100 + lo (14-bit, max 9999) and count_valid SHALL pulse in the same cycle as that byte's rx_done.
REQ-013 If hi > 99 or lo > 99, count_value SHALL hold, count_valid SHALL stay low and frame_err SHALL pulse instead.
REQ-014 ss rise in HI_BYTE or LO_BYTE (incomplete frame, including mid-byte) SHALL discard partial data, pulse frame_err one cycle later, and return to IDLE.
REQ-015 If ss rise and the 8th sample edge are detected in the same cycle, the byte SHALL complete first and the ss rise SHALL be processed next cycle.
REQ-016 rx_done, count_valid and frame_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-017 While reset is high: all outputs 0, FSM = IDLE, bit counter, shift registers and stored hi byte 0, synchronizer flops 1 for ss and cpol for sclk.
REQ-018 Reset asserted mid-frame SHALL abort the frame without pulsing frame_err; reception SHALL resume only after a fresh ss fall.

Verification
REQ-019 Mode 0 (cpol=0, cpha=0), frame bytes 0x0C, 0x22 -> rx_done twice with rx_data 0x0C then 0x22; count_valid once; count_value = 1234.
REQ-020 Modes 1, 2, 3 each with bytes 0x63, 0x63 -> count_value = 9999, no frame_err.
REQ-021 Frame bytes 0x64, 0x00 -> frame_err one pulse; count_value holds its prior value; no count_valid.
REQ-022 ss rises after 5 bits of the hi byte -> frame_err one pulse, no rx_done; next full frame 0x00, 0x07 -> count_value = 7.
REQ-023 Frame 0x01, 0x02 then frame 0x03, 0x04 -> miso shifts out 0x00 during frame 1 and 0x02 during frame 2.
REQ-024 Reset pulsed after hi byte -> no count_valid, no frame_err; following frame 0x00, 0x05 -> count_value = 5.
